// File: rtl/jtvigil_romrd.sv
// ROM read arbiter: three renderer clients (obj > scr1 > scr2) share one SDRAM
// read port, each client keeping a single cached 32-bit word with an address tag.
module jtvigil_romrd #(
    parameter logic [21:0] SCR1_OFFSET = 22'h00000,
    parameter logic [21:0] SCR2_OFFSET = 22'h10000,
    parameter logic [21:0] OBJ_OFFSET  = 22'h30000
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [16:0] scr1_addr,
    input  logic        scr1_cs,
    output logic        scr1_ok,
    output logic [31:0] scr1_data,

    input  logic [17:0] scr2_addr,
    input  logic        scr2_cs,
    output logic        scr2_ok,
    output logic [31:0] scr2_data,

    input  logic [17:0] obj_addr,
    input  logic        obj_cs,
    output logic        obj_ok,
    output logic [31:0] obj_data,

    output logic [21:0] sdram_addr,
    output logic        sdram_rd,
    input  logic        sdram_ack,
    input  logic        data_rdy,
    input  logic [31:0] data_read
);

    // SDRAM handshake: sdram_rd/sdram_addr are held until the single-cycle
    // sdram_ack; one data_rdy pulse then returns data_read. Pulses arriving
    // outside the state that expects them are ignored.
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    typedef enum logic [1:0] {SRC_OBJ, SRC_SCR1, SRC_SCR2} src_t;

    state_t      state;
    src_t        win;
    logic [17:0] win_addr;

    logic [16:0] scr1_tag;
    logic [17:0] scr2_tag;
    logic [17:0] obj_tag;
    logic        scr1_valid, scr2_valid, obj_valid;

    logic scr1_hit, scr2_hit, obj_hit;
    logic scr1_miss, scr2_miss, obj_miss;

    assign scr1_hit  = scr1_cs & scr1_valid & (scr1_addr == scr1_tag);
    assign scr2_hit  = scr2_cs & scr2_valid & (scr2_addr == scr2_tag);
    assign obj_hit   = obj_cs  & obj_valid  & (obj_addr  == obj_tag);
    assign scr1_miss = scr1_cs & ~scr1_hit;
    assign scr2_miss = scr2_cs & ~scr2_hit;
    assign obj_miss  = obj_cs  & ~obj_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            win        <= SRC_OBJ;
            win_addr   <= '0;
            sdram_rd   <= 1'b0;
            sdram_addr <= '0;
            scr1_ok    <= 1'b0;
            scr2_ok    <= 1'b0;
            obj_ok     <= 1'b0;
            scr1_data  <= '0;
            scr2_data  <= '0;
            obj_data   <= '0;
            scr1_tag   <= '0;
            scr2_tag   <= '0;
            obj_tag    <= '0;
            scr1_valid <= 1'b0;
            scr2_valid <= 1'b0;
            obj_valid  <= 1'b0;
        end else begin
            // ok reflects the inputs seen one cycle earlier against the cache
            // contents before any write on this edge.
            scr1_ok <= scr1_hit;
            scr2_ok <= scr2_hit;
            obj_ok  <= obj_hit;

            case (state)
                IDLE: begin
                    if (obj_miss) begin
                        win        <= SRC_OBJ;
                        win_addr   <= obj_addr;
                        sdram_addr <= {4'd0, obj_addr} + OBJ_OFFSET;
                        sdram_rd   <= 1'b1;
                        state      <= REQ;
                    end else if (scr1_miss) begin
                        win        <= SRC_SCR1;
                        win_addr   <= {1'b0, scr1_addr};
                        sdram_addr <= {5'd0, scr1_addr} + SCR1_OFFSET;
                        sdram_rd   <= 1'b1;
                        state      <= REQ;
                    end else if (scr2_miss) begin
                        win        <= SRC_SCR2;
                        win_addr   <= scr2_addr;
                        sdram_addr <= {4'd0, scr2_addr} + SCR2_OFFSET;
                        sdram_rd   <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (sdram_ack) begin
                        sdram_rd <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // The tag is the address latched at request time, so a client
                    // that moved on meanwhile sees a mismatch rather than stale data.
                    if (data_rdy) begin
                        case (win)
                            SRC_OBJ: begin
                                obj_data  <= data_read;
                                obj_tag   <= win_addr;
                                obj_valid <= 1'b1;
                            end
                            SRC_SCR1: begin
                                scr1_data  <= data_read;
                                scr1_tag   <= win_addr[16:0];
                                scr1_valid <= 1'b1;
                            end
                            default: begin
                                scr2_data  <= data_read;
                                scr2_tag   <= win_addr;
                                scr2_valid <= 1'b1;
                            end
                        endcase
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtvigil_romrd.sv
// Bench for jtvigil_romrd: directed scenarios plus randomized traffic, all
// compared each cycle against a cache/arbitration reference model.
module tb_jtvigil_romrd;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] scr1_addr;
    logic        scr1_cs;
    logic        scr1_ok;
    logic [31:0] scr1_data;
    logic [17:0] scr2_addr;
    logic        scr2_cs;
    logic        scr2_ok;
    logic [31:0] scr2_data;
    logic [17:0] obj_addr;
    logic        obj_cs;
    logic        obj_ok;
    logic [31:0] obj_data;
    logic [21:0] sdram_addr;
    logic        sdram_rd;
    logic        sdram_ack;
    logic        data_rdy;
    logic [31:0] data_read;

    jtvigil_romrd dut (
        .clk(clk), .rst(rst),
        .scr1_addr(scr1_addr), .scr1_cs(scr1_cs), .scr1_ok(scr1_ok), .scr1_data(scr1_data),
        .scr2_addr(scr2_addr), .scr2_cs(scr2_cs), .scr2_ok(scr2_ok), .scr2_data(scr2_data),
        .obj_addr(obj_addr), .obj_cs(obj_cs), .obj_ok(obj_ok), .obj_data(obj_data),
        .sdram_addr(sdram_addr), .sdram_rd(sdram_rd), .sdram_ack(sdram_ack),
        .data_rdy(data_rdy), .data_read(data_read)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference model; client index 0=obj, 1=scr1, 2=scr2 (priority order)
    logic [21:0] offs[3];
    logic        m_valid[3];
    logic [17:0] m_tag[3];
    logic [31:0] m_data[3];
    logic        exp_ok[3];
    logic        exp_rd;
    logic [21:0] exp_addr;
    int          m_phase;      // 0 no request, 1 request posted, 2 awaiting data
    int          m_win;
    logic [17:0] m_waddr;
    int          req_count;

    // SDRAM responder controls
    int          ack_dly, rdy_dly, req_cnt, wait_cnt;
    bit          rnd_dly, spur_rnd, spur_once, use_fixed;
    logic [31:0] fixed_data;

    function automatic logic [31:0] mem_word(input logic [21:0] a);
        return ({10'd0, a} * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic cs_of(input int i);
        case (i)
            0: return obj_cs;
            1: return scr1_cs;
            default: return scr2_cs;
        endcase
    endfunction

    function automatic logic [17:0] addr_of(input int i);
        case (i)
            0: return obj_addr;
            1: return {1'b0, scr1_addr};
            default: return scr2_addr;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_data[i]  = '0;
            exp_ok[i]  = 1'b0;
        end
        exp_rd   = 1'b0;
        exp_addr = '0;
        m_phase  = 0;
        m_win    = 0;
        m_waddr  = '0;
        req_cnt  = 0;
        wait_cnt = 0;
    endtask

    // Applies one clock edge worth of rules to the model using pre-edge inputs.
    task automatic model_update();
        logic hit[3];
        int w;
        w = -1;
        for (int i = 0; i < 3; i++) begin
            hit[i] = cs_of(i) && m_valid[i] && (addr_of(i) == m_tag[i]);
            if (cs_of(i) && !hit[i] && w < 0) w = i;
        end
        if (m_phase == 0) begin
            if (w >= 0) begin
                m_win    = w;
                m_waddr  = addr_of(w);
                exp_addr = {4'd0, addr_of(w)} + offs[w];
                exp_rd   = 1'b1;
                m_phase  = 1;
                req_cnt  = 0;
                req_count++;
                if (rnd_dly) begin
                    ack_dly = $urandom_range(0, 3);
                    rdy_dly = $urandom_range(0, 3);
                end
            end
        end else if (m_phase == 1) begin
            if (sdram_ack) begin
                exp_rd   = 1'b0;
                m_phase  = 2;
                wait_cnt = 0;
            end
        end else begin
            if (data_rdy) begin
                m_valid[m_win] = 1'b1;
                m_tag[m_win]   = m_waddr;
                m_data[m_win]  = data_read;
                m_phase        = 0;
            end
        end
        for (int i = 0; i < 3; i++) exp_ok[i] = hit[i];
    endtask

    task automatic check_outputs();
        check("obj_ok", obj_ok, exp_ok[0]);
        check("scr1_ok", scr1_ok, exp_ok[1]);
        check("scr2_ok", scr2_ok, exp_ok[2]);
        check("obj_data", obj_data, m_data[0]);
        check("scr1_data", scr1_data, m_data[1]);
        check("scr2_data", scr2_data, m_data[2]);
        check("sdram_rd", sdram_rd, exp_rd);
        check("sdram_addr", sdram_addr, exp_addr);
    endtask

    // driver: one full clock cycle, returns at posedge+1
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        if (m_phase == 1) begin
            if (req_cnt >= ack_dly) sdram_ack = 1'b1;
            else req_cnt++;
        end else if (spur_once || (spur_rnd && $urandom_range(0, 15) == 0)) begin
            sdram_ack = 1'b1;
        end
        if (m_phase == 2) begin
            if (wait_cnt >= rdy_dly) begin
                data_rdy  = 1'b1;
                data_read = use_fixed ? fixed_data : mem_word(exp_addr);
            end else begin
                wait_cnt++;
            end
        end else if (spur_once || (spur_rnd && $urandom_range(0, 15) == 0)) begin
            data_rdy  = 1'b1;
            data_read = 32'hBADBAD00 ^ $urandom;
        end
        spur_once = 1'b0;
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag, input logic [21:0] exp_a);
        int k;
        k = 0;
        while (m_phase != 1 && k < 40) begin
            cycle();
            k++;
        end
        check({tag, "_seen"}, (m_phase == 1) ? 32'd1 : 32'd0, 32'd1);
        check(tag, sdram_addr, exp_a);
    endtask

    task automatic wait_ok(input string tag, input int i, input int budget);
        logic got;
        got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            cycle();
            got = (i == 0) ? obj_ok : (i == 1) ? scr1_ok : scr2_ok;
        end
        check(tag, got, 1'b1);
    endtask

    task automatic set_idle_clients();
        obj_cs  = 1'b0;
        scr1_cs = 1'b0;
        scr2_cs = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        offs[0] = 22'h30000;
        offs[1] = 22'h00000;
        offs[2] = 22'h10000;
        rst = 1'b1;
        scr1_addr = '0; scr2_addr = '0; obj_addr = '0;
        set_idle_clients();
        sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
        rnd_dly = 1'b0; spur_rnd = 1'b0; spur_once = 1'b0; use_fixed = 1'b0;
        fixed_data = '0; ack_dly = 0; rdy_dly = 0; req_count = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd", sdram_rd, 1'b0);
        check("rst_addr", sdram_addr, 22'h0);
        check("rst_obj_ok", obj_ok, 1'b0);
        check("rst_obj_data", obj_data, 32'h0);
        rst = 1'b0;
        cycle();

        // single obj fetch with back-to-back ack/rdy
        use_fixed = 1'b1; fixed_data = 32'hDEADBEEF;
        obj_cs = 1'b1; obj_addr = 18'h00010;
        wait_req("t1_addr", 22'h30010);
        cycle();
        wait_ok("t1_ok", 0, 4);
        check("t1_data", obj_data, 32'hDEADBEEF);
        n0 = req_count;
        repeat (6) cycle();
        check("t1_norefetch", sdram_rd, 1'b0);
        check("t1_reqs", req_count, n0);
        use_fixed = 1'b0;

        // single-entry cache: moving away and back refetches
        obj_addr = 18'h00011;
        wait_req("t2_addr11", 22'h30011);
        wait_ok("t2_ok11", 0, 6);
        obj_addr = 18'h00010;
        wait_req("t2_addr10", 22'h30010);
        wait_ok("t2_ok10", 0, 6);

        // three simultaneous misses served in priority order
        obj_addr = 18'h00020; scr1_addr = 17'h00040; scr2_addr = 18'h00050;
        scr1_cs = 1'b1; scr2_cs = 1'b1;
        wait_req("t3_obj", 22'h30020);
        wait_ok("t3_obj_ok", 0, 6);
        wait_req("t3_scr1", 22'h00040);
        wait_ok("t3_scr1_ok", 1, 6);
        wait_req("t3_scr2", 22'h10050);
        wait_ok("t3_scr2_ok", 2, 6);

        // spurious ack/rdy while idle and all clients hitting
        repeat (2) cycle();
        n0 = req_count;
        spur_once = 1'b1;
        repeat (3) cycle();
        check("t6_obj_ok", obj_ok, 1'b1);
        check("t6_obj_data", obj_data, mem_word(22'h30020));
        check("t6_scr2_data", scr2_data, mem_word(22'h10050));
        check("t6_reqs", req_count, n0);

        // scr2 moves to a new address while its fetch is in flight
        set_idle_clients();
        scr2_cs = 1'b1; scr2_addr = 18'h00100; rdy_dly = 2;
        wait_req("t4_addr100", 22'h10100);
        for (int k = 0; k < 10 && m_phase != 2; k++) cycle();
        scr2_addr = 18'h00200;
        wait_req("t4_addr200", 22'h10200);
        check("t4_ok_low", scr2_ok, 1'b0);
        wait_ok("t4_ok200", 2, 8);

        // async reset while waiting for data
        set_idle_clients();
        obj_cs = 1'b1; obj_addr = 18'h00077; rdy_dly = 6;
        wait_req("t5_addr", 22'h30077);
        for (int k = 0; k < 10 && m_phase != 2; k++) cycle();
        cycle();
        #2;
        rst = 1'b1;
        set_idle_clients();
        #1;
        check("t5_rd_async", sdram_rd, 1'b0);
        check("t5_obj_ok_async", obj_ok, 1'b0);
        check("t5_scr1_ok_async", scr1_ok, 1'b0);
        check("t5_scr2_ok_async", scr2_ok, 1'b0);
        rst = 1'b0;
        model_reset();
        rdy_dly = 0;
        spur_once = 1'b1;
        repeat (3) cycle();
        check("t5_ok_after", obj_ok | scr1_ok | scr2_ok, 1'b0);
        obj_cs = 1'b1; obj_addr = 18'h00020;
        wait_req("t5_refetch", 22'h30020);
        wait_ok("t5_ok_refetch", 0, 6);

        // randomized traffic
        rnd_dly = 1'b1;
        spur_rnd = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            cycle();
            if ($urandom_range(0, 3) == 0) obj_cs = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) scr1_cs = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) scr2_cs = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) obj_addr = 18'($urandom_range(0, 3)) | (($urandom_range(0, 1) != 0) ? 18'h3FFF0 : 18'h0);
            if ($urandom_range(0, 5) == 0) scr1_addr = 17'($urandom_range(0, 3)) | (($urandom_range(0, 1) != 0) ? 17'h1FFF0 : 17'h0);
            if ($urandom_range(0, 5) == 0) scr2_addr = 18'($urandom_range(0, 3)) | (($urandom_range(0, 1) != 0) ? 18'h2AAA0 : 18'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
